rv_instr_stim_gen: RTL and testbench
====================================

// Module: rv_instr_stim_gen
// PURPOSE
//  Synthesizable constrained-random RV32I instruction source for the sodor pipeline verif harness.
//  Replaces per-test $urandom stimulus with a seeded on-chip LFSR generator that supports:
//   - several instruction classes (I-type ALU, R-type ALU, LUI), runtime-selectable;
//   - a valid/ready handshake and a bounded instruction count.
//  Sits between the harness and the core imem response port; emits legal, encodable words only.
// PARAMETERS
//  WORD_SIZE  32   instruction/data word width (only 32 supported)
//  NUM_REGS   32   architectural registers; register fields are 5 bits
//  SEED       649  LFSR seed (36-bit, zero-extended); SEED==0 is replaced by 1
//  NUM_INSTR  64   instructions per run; 0 = unlimited
// PORTS
//  clk          in   1   clock, rising edge
//  reset        in   1   async, active-high; clears all state
//  start        in   1   one-cycle pulse: begin a run (ignored unless IDLE or DONE)
//  class_mask   in   3   enable mask: bit0 ITYPE, bit1 RTYPE, bit2 LUI; sampled at start
//  instr_valid  out  1   instr is a generated instruction
//  instr_ready  in   1   consumer accepts instr this cycle
//  instr        out  32  instruction word; 32'h00000013 (NOP) whenever !instr_valid
//  instr_cnt    out  16  instructions accepted in the current run
//  done         out  1   run finished (NUM_INSTR accepted)
// BEHAVIOUR
//  Reset values: instr_valid=0, instr=32'h13, instr_cnt=0, done=0, state=IDLE, lfsr=SEED.
//  LFSR r[35:0], Fibonacci: next={r[34:0], r[35]^r[24]}. Advances only on accept (valid&&ready).
//  FSM:
//   IDLE -start-> RUN.
//   RUN: valid=1. On accept, cnt+1. If cnt+1==NUM_INSTR (NUM_INSTR!=0) -> DONE.
//   DONE: valid=0, done=1. start -> RUN, with cnt cleared; LFSR is NOT reseeded.
//   start while RUN: ignored.
//  Output is registered from current r. Next word is visible the cycle after accept. Throughput 1/cycle.
//  While valid && !ready: instr, instr_valid and r are held stable.
//  Field map: rd=r[4:0], rs1=r[9:5], rs2=r[14:10], f3=r[17:15], imm=r[29:18], cls=r[31:30].
//  Class select:
//   cls 3 -> ITYPE.
//   Disabled class -> lowest enabled class.
//   class_mask==0 behaves as 3'b001.
//  ITYPE {imm,rs1,f3,rd,7'h13}. Shift legalisation:
//   f3==1 -> imm&12'h01F.
//   f3==5 -> imm&12'h41F.
//  RTYPE {f7,rs2,rs1,f3,rd,7'h33}: f7=7'h20 iff r[29] && f3 in {0,5}, else 7'h00.
//  LUI  {r[31:12],rd,7'h37}.
//  instr_cnt saturates at 16'hFFFF in unlimited mode.
//  Reset mid-run: returns to IDLE immediately; the in-flight word is dropped; the LFSR is reseeded.
// CONFIGURATION
//  HAZARD_BIAS_EN defined:
//   - last accepted rd is tracked;
//   - when r[33:32]==2'b00 (~25%), rs1 is replaced by last_rd, which forces RAW forwarding paths;
//   - the tracked rd resets to 0.
//  HAZARD_BIAS_EN undefined: rs1 comes from r[9:5] only; no tracking register.
// STRUCTURE
//  Package rv_stim_pkg holds:
//   - OPC_OP_IMM=7'h13, OPC_OP=7'h33, OPC_LUI=7'h37, NOP_INSTR=32'h00000013;
//   - cls_e {CLS_ITYPE, CLS_RTYPE, CLS_LUI}; state_e {IDLE, RUN, DONE}.
//  Sub-module rv_stim_lfsr (36-bit, parameter SEED, input adv) owns the LFSR.
//  The top owns the FSM, encoding and handshake.
// TESTING
//  1. Reset held 3 cycles, then released, no start -> instr==32'h13, valid=0, cnt=0 every cycle.
//  2. NUM_INSTR=8, mask=3'b001, ready=1, start -> 8 consecutive valid ITYPE (opcode 7'h13)
//     -> done=1, cnt=8, valid=0.
//  3. ready toggled 1,0,0,1 during RUN -> instr bit-identical across stall cycles; cnt increments only on ready.
//  4. mask=3'b010, 200 instrs -> all opcode 7'h33; f7 is 7'h20 only with f3 0/5, else 7'h00.
//  5. mask=3'b001, 500 instrs -> every f3==1 word has imm[11:5]==0; every f3==5 word has imm[11:5] in {0,7'h20}.
//  6. Reset asserted mid-run at cnt=3, then start again, SEED=649
//     -> the first word equals the first word of a fresh run (same seed replay).

Source files
------------

// File: rtl/rv_stim_pkg.sv
// Shared definitions for the RV32I constrained-random instruction source:
// opcodes, the idle NOP word, instruction classes and FSM states.
package rv_stim_pkg;

  localparam logic [6:0]  OPC_OP_IMM = 7'h13;
  localparam logic [6:0]  OPC_OP     = 7'h33;
  localparam logic [6:0]  OPC_LUI    = 7'h37;
  localparam logic [31:0] NOP_INSTR  = 32'h00000013;

  typedef enum logic [1:0] {CLS_ITYPE, CLS_RTYPE, CLS_LUI} cls_e;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  // Map the two random class bits onto an enabled class. Code 3 folds onto
  // ITYPE, a disabled pick falls back to the lowest enabled class, and an
  // all-zero mask is treated as ITYPE-only so the generator never stalls.
  function automatic cls_e pick_class(input logic [1:0] cls_bits,
                                      input logic [2:0] mask);
    logic [2:0] eff;
    cls_e       want;
    logic       enabled;
    eff = (mask == 3'b000) ? 3'b001 : mask;
    case (cls_bits)
      2'd1:    want = CLS_RTYPE;
      2'd2:    want = CLS_LUI;
      default: want = CLS_ITYPE;
    endcase
    case (want)
      CLS_RTYPE: enabled = eff[1];
      CLS_LUI:   enabled = eff[2];
      default:   enabled = eff[0];
    endcase
    if (!enabled) begin
      if (eff[0])      want = CLS_ITYPE;
      else if (eff[1]) want = CLS_RTYPE;
      else             want = CLS_LUI;
    end
    return want;
  endfunction

endpackage

// File: rtl/rv_stim_lfsr.sv
// 36-bit Fibonacci LFSR that feeds the instruction encoder. It only moves
// when the consumer accepts a word, so a stalled word stays stable.
module rv_stim_lfsr
  import rv_stim_pkg::*;
#(
  parameter logic [35:0] SEED = 36'd649
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        adv,
  output logic [35:0] r
);

  // An all-zero state would lock the register, so a zero seed becomes 1.
  localparam logic [35:0] SEED_VAL = (SEED == 36'd0) ? 36'd1 : SEED;

  // Reseed on reset, otherwise shift in the r[35]^r[24] feedback per accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)    r <= SEED_VAL;
    else if (adv) r <= {r[34:0], r[35] ^ r[24]};
  end

endmodule

// File: rtl/rv_instr_stim_gen.sv
// Constrained-random RV32I instruction source with valid/ready handshake and
// a bounded per-run instruction count. Optional feature macro:
// HAZARD_BIAS_EN - bias rs1 towards the last accepted rd to provoke RAW hazards.
module rv_instr_stim_gen
  import rv_stim_pkg::*;
#(
  parameter int          WORD_SIZE = 32,
  parameter int          NUM_REGS  = 32,
  parameter logic [35:0] SEED      = 36'd649,
  parameter int          NUM_INSTR = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [2:0]           class_mask,
  output logic                 instr_valid,
  input  logic                 instr_ready,
  output logic [WORD_SIZE-1:0] instr,
  output logic [15:0]          instr_cnt,
  output logic                 done
);

  localparam int REG_W = $clog2(NUM_REGS);

  state_e          state_q, state_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [2:0]      mask_q, mask_d;
  logic [35:0]     r;
  logic            accept;
  logic [16:0]     cnt_inc;
  logic [REG_W-1:0] rd, rs1, rs2;
  logic [2:0]      f3;
  logic [11:0]     imm, imm_legal;
  logic [6:0]      f7;
  cls_e            cls;
  logic [WORD_SIZE-1:0] word;
  logic            unused_hi;

  assign instr_valid = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign instr_cnt   = cnt_q;
  assign accept      = instr_valid && instr_ready;
  assign cnt_inc     = {1'b0, cnt_q} + 17'd1;
  assign unused_hi   = ^r[35:32];

  rv_stim_lfsr #(.SEED(SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .adv   (accept),
    .r     (r)
  );

  // State, run counter and the class mask captured at start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mask_q  <= 3'b001;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
    end
  end

  // Next-state logic: start is honoured only from IDLE/DONE; RUN counts
  // accepts and ends the run when the configured count is reached.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
          mask_d  = class_mask;
        end
      end
      RUN: begin
        if (accept) begin
          if (cnt_q != 16'hFFFF) cnt_d = cnt_inc[15:0];
          if ((NUM_INSTR != 0) && (cnt_inc == 17'(NUM_INSTR))) state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef HAZARD_BIAS_EN
  logic [REG_W-1:0] last_rd;

  // Remember the destination of the last accepted word for rs1 biasing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       last_rd <= '0;
    else if (accept) last_rd <= rd;
  end
`endif

  // Decode LFSR fields into a legal word of the selected class; NOP when idle.
  always_comb begin
    rd        = r[REG_W-1:0];
    rs1       = r[5 +: REG_W];
    rs2       = r[10 +: REG_W];
    f3        = r[17:15];
    imm       = r[29:18];
    imm_legal = imm;
    f7        = 7'h00;
    word      = NOP_INSTR;
`ifdef HAZARD_BIAS_EN
    if (r[33:32] == 2'b00) rs1 = last_rd;
`endif
    cls = pick_class(r[31:30], mask_q);
    case (cls)
      CLS_ITYPE: begin
        if (f3 == 3'd1)      imm_legal = imm & 12'h01F;
        else if (f3 == 3'd5) imm_legal = imm & 12'h41F;
        word = {imm_legal, rs1, f3, rd, OPC_OP_IMM};
      end
      CLS_RTYPE: begin
        if (r[29] && ((f3 == 3'd0) || (f3 == 3'd5))) f7 = 7'h20;
        word = {f7, rs2, rs1, f3, rd, OPC_OP};
      end
      CLS_LUI:  word = {r[31:12], rd, OPC_LUI};
      default:  word = NOP_INSTR;
    endcase
    instr = instr_valid ? word : NOP_INSTR;
  end

endmodule

// File: tb/tb_rv_instr_stim_gen.sv
// Scoreboard bench for rv_instr_stim_gen: the driver pushes the words a
// behavioural model predicts for each run, the monitor pops on every accept.
module tb_rv_instr_stim_gen;

  localparam int          N_RUN = 8;
  localparam logic [35:0] SEED  = 36'd649;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  class_mask;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [15:0] instr_cnt;
  logic        done;

  int          n_checks = 0;
  int          n_fails  = 0;
  logic [31:0] exp_q[$];
  logic [35:0] m_r;
  logic [4:0]  m_last_rd;

  rv_instr_stim_gen #(
    .WORD_SIZE (32),
    .NUM_REGS  (32),
    .SEED      (SEED),
    .NUM_INSTR (N_RUN)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .class_mask  (class_mask),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_cnt   (instr_cnt),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Global time limit so the bench can never hang.
  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance the reference LFSR by one accepted word.
  function automatic logic [35:0] lfsr_step(input logic [35:0] v);
    logic fb;
    fb = v[35] ^ v[24];
    return {v[34:0], fb};
  endfunction

  // Reference encoder written from the field rules with plain arithmetic.
  function automatic logic [31:0] model_word(input logic [35:0] r,
                                             input logic [2:0] mask,
                                             input logic [4:0] last_rd);
    int unsigned lo, rd, rs1, rs2, f3, imm, kind, eff, f7, top;
    lo   = r[31:0];
    top  = 32'(r >> 32);
    rd   = lo % 32;
    rs1  = (lo >> 5) % 32;
    rs2  = (lo >> 10) % 32;
    f3   = (lo >> 15) % 8;
    imm  = (lo >> 18) % 4096;
    kind = lo >> 30;
`ifdef HAZARD_BIAS_EN
    if (top % 4 == 0) rs1 = 32'(last_rd);
`else
    if (top > 15 && last_rd > 31) rs1 = 0;
`endif
    eff = (mask == 3'b000) ? 1 : 32'(mask);
    if (kind == 3) kind = 0;
    if (((eff >> kind) & 1) == 0) kind = (eff & 1) != 0 ? 0 : ((eff & 2) != 0 ? 1 : 2);
    if (kind == 0) begin
      if (f3 == 1) imm = imm % 32;
      if (f3 == 5) imm = imm & 32'h41F;
      return (imm << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h13;
    end else if (kind == 1) begin
      f7 = (((lo >> 29) & 1) == 1 && (f3 == 0 || f3 == 5)) ? 32'h20 : 0;
      return (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h33;
    end
    return (lo & 32'hFFFFF000) | (rd << 7) | 32'h37;
  endfunction

  // Predict a whole run's words and hand them to the scoreboard.
  task automatic push_run(input logic [2:0] mask);
    for (int i = 0; i < N_RUN; i++) begin
      exp_q.push_back(model_word(m_r, mask, m_last_rd));
      m_last_rd = m_r[4:0];
      m_r       = lfsr_step(m_r);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_r       = SEED;
    m_last_rd = 5'd0;
  endtask

  task automatic pulse_start(input logic [2:0] mask);
    @(posedge clk); #1;
    start      = 1'b1;
    class_mask = mask;
    push_run(mask);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // One complete run with ready asserted ready_pct percent of the time.
  task automatic apply_stimulus(input logic [2:0] mask, input int ready_pct);
    int budget;
    pulse_start(mask);
    budget = 0;
    while (!done && budget < 400) begin
      instr_ready = ($urandom_range(99) < ready_pct);
      @(posedge clk); #1;
      budget++;
    end
    instr_ready = 1'b0;
    check_output("run_done", 32'(done), 32'd1);
    check_output("run_cnt", 32'(instr_cnt), N_RUN);
    check_output("run_valid_low", 32'(instr_valid), 32'd0);
  endtask

  // Monitor: compare every accepted word, check idle NOPs, stall stability
  // and the legality rules of shift and R-type encodings.
  logic        prev_stall = 1'b0;
  logic [31:0] prev_instr = 32'h0;
  always @(negedge clk) begin
    if (reset) begin
      prev_stall <= 1'b0;
    end else begin
      if (!instr_valid) check_output("idle_nop", instr, 32'h13);
      if (instr_valid && prev_stall) check_output("stall_hold", instr, prev_instr);
      if (instr_valid && instr_ready) begin
        if (exp_q.size() == 0) begin
          check_output("sb_underflow", 32'(exp_q.size()), 32'd1);
        end else begin
          check_output("sb_word", instr, exp_q.pop_front());
        end
        if (instr[6:0] == 7'h33)
          check_output("rtype_f7_legal",
                       32'((instr[31:25] == 7'h00) ||
                           (instr[31:25] == 7'h20 && (instr[14:12] == 3'd0 || instr[14:12] == 3'd5))),
                       32'd1);
        if (instr[6:0] == 7'h13 && instr[14:12] == 3'd1)
          check_output("slli_imm", 32'(instr[31:25]), 32'd0);
        if (instr[6:0] == 7'h13 && instr[14:12] == 3'd5)
          check_output("srxi_imm", 32'(instr[31:25] == 7'h00 || instr[31:25] == 7'h20), 32'd1);
      end
      prev_stall <= instr_valid && !instr_ready;
      prev_instr <= instr;
    end
  end

  initial begin
    logic [31:0] fresh_first;
    logic [31:0] held;
    logic [15:0] cnt_before;
    logic [7:0]  pattern;
    int          budget;

    reset       = 1'b1;
    start       = 1'b0;
    instr_ready = 1'b0;
    class_mask  = 3'b001;
    model_reset();
    fresh_first = model_word(SEED, 3'b001, 5'd0);

    // Reset held for three cycles, then idle without start.
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_output("reset_valid", 32'(instr_valid), 32'd0);
      check_output("reset_instr", instr, 32'h13);
      check_output("reset_cnt", 32'(instr_cnt), 32'd0);
      check_output("reset_done", 32'(done), 32'd0);
    end

    // First ITYPE run at full throughput.
    apply_stimulus(3'b001, 100);

    // Stall pattern: count moves only on ready, word held across stalls.
    pulse_start(3'b001);
    pattern = 8'b0110_1001;
    for (int i = 0; i < 8; i++) begin
      instr_ready = pattern[i];
      held        = instr;
      cnt_before  = instr_cnt;
      @(posedge clk); #1;
      check_output("stall_cnt", 32'(instr_cnt), 32'(cnt_before) + 32'(pattern[i]));
      if (!pattern[i]) check_output("stall_word", instr, held);
    end
    budget = 0;
    instr_ready = 1'b1;
    while (!done && budget < 50) begin
      @(posedge clk); #1;
      budget++;
    end
    instr_ready = 1'b0;
    check_output("stall_run_done", 32'(done), 32'd1);

    // R-type only, then ITYPE only with heavy shift coverage.
    for (int i = 0; i < 25; i++) apply_stimulus(3'b010, 70);
    for (int i = 0; i < 63; i++) apply_stimulus(3'b001, 80);

    // Mixed and degenerate masks exercise the class fallback.
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(3'b100, 60);
      apply_stimulus(3'b110, 60);
      apply_stimulus(3'b000, 60);
      apply_stimulus(3'b111, 60);
      apply_stimulus(3'b011, 60);
    end

    // Reset in the middle of a run, then replay from the seed.
    pulse_start(3'b001);
    instr_ready = 1'b1;
    budget = 0;
    while (instr_cnt != 16'd3 && budget < 50) begin
      @(posedge clk); #1;
      budget++;
    end
    check_output("mid_cnt", 32'(instr_cnt), 32'd3);
    reset       = 1'b1;
    instr_ready = 1'b0;
    model_reset();
    #1;
    check_output("mid_reset_valid", 32'(instr_valid), 32'd0);
    check_output("mid_reset_cnt", 32'(instr_cnt), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    pulse_start(3'b001);
    check_output("replay_first", instr, fresh_first);
    instr_ready = 1'b1;
    budget = 0;
    while (!done && budget < 50) begin
      @(posedge clk); #1;
      budget++;
    end
    instr_ready = 1'b0;
    check_output("replay_done", 32'(done), 32'd1);

    // Start is ignored while a run is in progress.
    pulse_start(3'b010);
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_output("start_in_run_cnt", 32'(instr_cnt), 32'd0);
    instr_ready = 1'b1;
    budget = 0;
    while (!done && budget < 50) begin
      @(posedge clk); #1;
      budget++;
    end
    instr_ready = 1'b0;
    check_output("start_in_run_done", 32'(done), 32'd1);

    repeat (3) @(posedge clk);
    check_output("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
